// File: rtl/ls_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// byte-lane selection helpers used by both the FSM and the lane datapath.
package ls_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } ls_state_e;

  // Big-endian mirrors the lane index: byte 0 lives in bits 31:24.
  function automatic logic [1:0] byte_lane(input logic [1:0] addr_lo, input bit big_endian);
    return big_endian ? ~addr_lo : addr_lo;
  endfunction

  function automatic logic half_lane(input logic addr_hi, input bit big_endian);
    return big_endian ? ~addr_hi : addr_hi;
  endfunction

endpackage

// File: rtl/ls_lane.sv
// Byte/half lane datapath: extracts and extends load data from a memory word,
// and merges sub-word store data into a word read back for read-modify-write.
module ls_lane
  import ls_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word_in,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [15:0] wdata_lo,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [1:0]  b_lane;
  logic        h_lane;
  logic [7:0]  b_val;
  logic [15:0] h_val;

  always_comb begin
    b_lane = byte_lane(addr_lo, BIG_ENDIAN);
    h_lane = half_lane(addr_lo[1], BIG_ENDIAN);
    b_val  = word_in[{b_lane, 3'b000} +: BYTE_BITS];
    h_val  = word_in[{h_lane, 4'b0000} +: HALF_BITS];

    load_data = word_in;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & b_val[7]}}, b_val};
      SZ_HALF: load_data = {{16{sign_ext & h_val[15]}}, h_val};
      default: load_data = word_in;
    endcase

    merged = word_in;
    if (size == SZ_BYTE) begin
      merged[{b_lane, 3'b000} +: BYTE_BITS] = wdata_lo[7:0];
    end else if (size == SZ_HALF) begin
      merged[{h_lane, 4'b0000} +: HALF_BITS] = wdata_lo;
    end
  end

endmodule

// File: rtl/ls_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores are done
// as read-modify-write, bad requests are answered without touching memory.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_LOAD   | memory read, capture extended load data
// ST_RMW_RD | memory read, merge sub-word store data into buffer
// ST_WRITE  | memory write of buffer
// ST_RESP   | one-cycle response pulse
module ls_unit
  import ls_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_memIn,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_memOut
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  ls_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_bad;
  logic        accept;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  ls_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .word_in   (mem_memOut),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .sign_ext  (signed_q),
    .wdata_lo  (buf_q[15:0]),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  always_comb begin
    accept  = (state_q == ST_IDLE) && req_valid;
    req_bad = (req_size == SZ_ILL)
            || ((req_size == SZ_HALF) && req_addr[0])
            || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
            || ({1'b0, req_addr} >= ADDR_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      buf_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad)                  state_d = ST_RESP;
          else if (!req_write)          state_d = ST_LOAD;
          else if (req_size == SZ_WORD) state_d = ST_WRITE;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Response registers only change on the way into RESP, so they hold between responses.
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          if (req_bad) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_write) begin
            buf_d = req_wdata;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = lane_load;
        err_d   = 1'b0;
      end
      ST_RMW_RD: buf_d = lane_merged;
      ST_WRITE: begin
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    resp_valid   = (state_q == ST_RESP);
    mem_memRead  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    mem_memWrite = (state_q == ST_WRITE);
    mem_address  = {addr_q[31:2], 2'b00};
    mem_memIn    = buf_q;
    resp_rdata   = rdata_q;
    resp_err     = err_q;
  end

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit with a behavioural word memory and a response
// scoreboard that checks data, error flag and accept-to-response latency.
module tb_ls_unit;
  import ls_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_memIn;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_memOut;

  always #5 clk = ~clk;

  ls_unit #(.MEM_WORDS(1024), .BIG_ENDIAN(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_memIn    (mem_memIn),
    .mem_memRead  (mem_memRead),
    .mem_memWrite (mem_memWrite),
    .mem_memOut   (mem_memOut)
  );

  // Word memory: combinational read, write at the rising edge.
  logic [31:0] mem [0:1023];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    if (mem_memWrite) mem[mem_address[11:2]] <= mem_memIn;
  end

  assign mem_memOut = mem_memRead ? mem[mem_address[11:2]] : 32'hBAD0_BAD0;

  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] rd_addr = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_memRead) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= mem_address;
    end
    if (mem_memWrite) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_address;
      wr_data <= mem_memIn;
    end
    if (mem_memRead && mem_memWrite) both_cnt <= both_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    checks++;
    assert (sbq.size() != 0)
    else begin
      failures++;
      $error("FAIL resp_unexpected observed=1 expected=0 at cycle %0d", cyc);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      chk("resp_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (resp_valid) check_resp();
  endtask

  task automatic send(input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_err, input int lat,
                      input bit push, input bit hold);
    int budget;
    exp_t e;
    budget = 0;
    step();
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && budget < 50) begin
      step();
      budget++;
    end
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    last_acc = cyc + 1;
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = lat;
      e.acc   = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sbq.size() != 0 && budget < 50) begin
      step();
      budget++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_idx  = addr[11:2];
    pre_data = data;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  initial begin
    int r0;
    int w0;
    int a1;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = SZ_WORD;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    pre_en     = 1'b0;
    pre_idx    = '0;
    pre_data   = '0;

    poke(32'h10, 32'hDEAD_BEEF);
    poke(32'h20, 32'h80FF_7F01);
    poke(32'h30, 32'h1122_3344);
    poke(32'h40, 32'h0000_0000);

    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_read", {31'b0, mem_memRead}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_memWrite}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_in", mem_memIn, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word load
    r0 = rd_cnt;
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, 1'b0);
    drain();
    chk("wload_rd_pulses", 32'(rd_cnt - r0), 32'd1);
    chk("wload_rd_addr", rd_addr, 32'h10);

    // Sub-word loads from 0x80FF7F01
    send(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b1, 1'b0);
    send(1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b1, 1'b0);
    send(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1'b1, 1'b0);
    send(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h0000_80FF, 1'b0, 2, 1'b1, 1'b0);
    send(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 2, 1'b1, 1'b0);
    send(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 32'h0000_0001, 1'b0, 2, 1'b1, 1'b0);
    send(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 32'h0000_7F01, 1'b0, 2, 1'b1, 1'b0);
    drain();

    // Byte store read-modify-write
    r0 = rd_cnt;
    w0 = wr_cnt;
    send(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h0000_00AA, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    drain();
    chk("bstore_rd_pulses", 32'(rd_cnt - r0), 32'd1);
    chk("bstore_wr_pulses", 32'(wr_cnt - w0), 32'd1);
    chk("bstore_mem_in", wr_data, 32'h1122_AA44);
    chk("bstore_rd_addr", rd_addr, 32'h30);
    chk("bstore_wr_addr", wr_addr, 32'h30);
    chk("bstore_mem_word", mem[12], 32'h1122_AA44);
    send(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h1122_AA44, 1'b0, 2, 1'b1, 1'b0);

    // Half store into the upper lane
    send(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234_CAFE, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hCAFE_BEEF, 1'b0, 2, 1'b1, 1'b0);
    drain();

    // Rejected requests
    r0 = rd_cnt;
    w0 = wr_cnt;
    send(1'b0, SZ_HALF, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    send(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    send(1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    send(1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h5A5A_5A5A, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    send(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000_1111, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    drain();
    step();
    chk("err_held", {31'b0, resp_err}, 32'd1);
    chk("err_rd_pulses", 32'(rd_cnt - r0), 32'd0);
    chk("err_wr_pulses", 32'(wr_cnt - w0), 32'd0);
    chk("err_mem_0x10", mem[4], 32'hCAFE_BEEF);
    chk("err_mem_0x0", mem[0], mem[0] === 32'h5A5A_5A5A ? 32'h0 : mem[0]);

    // Back-to-back with req_valid held high
    send(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h0000_0055, 32'h0, 1'b0, 2, 1'b1, 1'b1);
    a1 = last_acc;
    send(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h0000_0055, 1'b0, 2, 1'b1, 1'b0);
    chk("b2b_accept_gap", 32'(last_acc - a1), 32'd3);
    drain();

    // Reset while the RMW read is in progress
    w0 = wr_cnt;
    send(1'b1, SZ_BYTE, 1'b0, 32'h30, 32'h0000_0077, 32'h0, 1'b0, 3, 1'b0, 1'b0);
    chk("rmw_rd_active", {31'b0, mem_memRead}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_mem_read", {31'b0, mem_memRead}, 32'd0);
    chk("rst_mid_mem_write", {31'b0, mem_memWrite}, 32'd0);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) step();
    chk("rst_mid_wr_pulses", 32'(wr_cnt - w0), 32'd0);
    chk("rst_mid_mem_word", mem[12], 32'h1122_AA44);
    chk("rst_mid_rdata", resp_rdata, 32'd0);
    chk("rst_mid_req_ready_after", {31'b0, req_ready}, 32'd1);
    send(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h1122_AA44, 1'b0, 2, 1'b1, 1'b0);
    drain();

    chk("read_write_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
